debug_scan_master: RTL and testbench

Host-side initiator for the CPU debug slave's virtual-JTAG port. It takes one command at a time, made of an IR value and a 38-bit shift word, and plays out the full scan sequence. It drives tck/tdi and the UIR/CDR/SDR/UDR/RTI state strobes, and returns the captured 38-bit word plus the 2-bit ir_out. It sits in the debug test harness and on-chip debug bridge, in place of the sld_virtual_jtag_basic hub, and connects point-to-point to the debug slave's vji_* pins.

---
 rtl/debug_scan_pkg.sv | 21 ++
 rtl/debug_scan_if.sv | 37 +++
 rtl/debug_scan_tck_gen.sv | 40 ++++
 rtl/debug_scan_master.sv | 148 ++++++++++++++
 tb/tb_debug_scan_master.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_scan_pkg.sv
// Shared types and constants for the virtual-JTAG debug scan master.
package debug_scan_pkg;

    localparam int unsigned DBG_SR_WIDTH = 38;
    localparam int unsigned DBG_IR_WIDTH = 2;

    localparam logic [1:0] DBG_IR_OCIMEM    = 2'b00;
    localparam logic [1:0] DBG_IR_TRACEMEM  = 2'b01;
    localparam logic [1:0] DBG_IR_BREAK     = 2'b10;
    localparam logic [1:0] DBG_IR_TRACECTRL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_UIR  = 3'd1,
        S_CDR  = 3'd2,
        S_SDR  = 3'd3,
        S_UDR  = 3'd4,
        S_RESP = 3'd5
    } scan_state_t;

endpackage

// File: rtl/debug_scan_if.sv
// Command/response handshake plus the vji_* pins of the debug slave.
interface debug_scan_if #(
    parameter int unsigned SR_WIDTH = debug_scan_pkg::DBG_SR_WIDTH,
    parameter int unsigned IR_WIDTH = debug_scan_pkg::DBG_IR_WIDTH
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [SR_WIDTH-1:0] cmd_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [SR_WIDTH-1:0] rsp_data;
    logic [IR_WIDTH-1:0] rsp_ir_out;
    logic                vji_tck;
    logic                vji_tdi;
    logic                vji_tdo;
    logic [IR_WIDTH-1:0] vji_ir_in;
    logic [IR_WIDTH-1:0] vji_ir_out;
    logic                vji_uir;
    logic                vji_cdr;
    logic                vji_sdr;
    logic                vji_udr;
    logic                vji_rti;

    modport master (
        input  cmd_valid, cmd_ir, cmd_data, rsp_ready, vji_tdo, vji_ir_out,
        output cmd_ready, rsp_valid, rsp_data, rsp_ir_out,
        output vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
    );

    modport slave (
        output cmd_valid, cmd_ir, cmd_data, rsp_ready, vji_tdo, vji_ir_out,
        input  cmd_ready, rsp_valid, rsp_data, rsp_ir_out,
        input  vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
    );

endinterface

// File: rtl/debug_scan_tck_gen.sv
// Half-period divider producing tck plus single-cycle rise/fall strobes.
module debug_scan_tck_gen #(
    parameter int unsigned TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    output logic o_tck,
    output logic o_rise_c,
    output logic o_fall_c
);

    localparam int unsigned CNT_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_tck;
    logic             w_wrap;

    assign w_wrap   = i_en && (r_cnt == CNT_W'(TCK_DIV - 1));
    assign o_rise_c = w_wrap && !r_tck;
    assign o_fall_c = w_wrap && r_tck;
    assign o_tck    = r_tck;

    // Disabling parks tck low with the divider cleared, so a new scan starts on a full low half.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_tck <= ~r_tck;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/debug_scan_master.sv
// Virtual-JTAG scan initiator: plays UIR/CDR/SDR/UDR for one command, returns the capture.
module debug_scan_master
    import debug_scan_pkg::*;
#(
    parameter int unsigned SR_WIDTH = DBG_SR_WIDTH,
    parameter int unsigned IR_WIDTH = DBG_IR_WIDTH,
    parameter int unsigned TCK_DIV  = 2
) (
    input  logic         clk,
    input  logic         reset,
    debug_scan_if.master bus
);

    localparam int unsigned BIT_W = $clog2(SR_WIDTH);

    scan_state_t         r_state;
    scan_state_t         w_state_nxt;
    logic [BIT_W-1:0]    r_bit;
    logic [BIT_W-1:0]    w_bit_nxt;
    logic                w_rsp_valid_nxt;
    logic                w_accept;
    logic                w_tck_en;
    logic                w_tck;
    logic                w_rise;
    logic                w_fall;

    logic                r_cmd_ready;
    logic                r_rsp_valid;
    logic [SR_WIDTH-1:0] r_rx;
    logic [SR_WIDTH-1:0] r_tx;
    logic [IR_WIDTH-1:0] r_ir_out;
    logic [IR_WIDTH-1:0] r_ir_in;
    logic                r_tdi;
    logic                r_uir;
    logic                r_cdr;
    logic                r_sdr;
    logic                r_udr;
    logic                r_rti;

    assign w_accept = (r_state == S_IDLE) && bus.cmd_valid && r_cmd_ready;
    assign w_tck_en = (r_state == S_UIR) || (r_state == S_CDR) ||
                      (r_state == S_SDR) || (r_state == S_UDR);

    debug_scan_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
        .clk      (clk),
        .reset    (reset),
        .i_en     (w_tck_en),
        .o_tck    (w_tck),
        .o_rise_c (w_rise),
        .o_fall_c (w_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_bit   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bit   <= w_bit_nxt;
        end
    end

    // Scan states advance only on tck falling edges, so vji outputs never move under a rise.
    always_comb begin
        w_state_nxt     = r_state;
        w_bit_nxt       = r_bit;
        w_rsp_valid_nxt = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_UIR;
            S_UIR:  if (w_fall)   w_state_nxt = S_CDR;
            S_CDR:  if (w_fall)   w_state_nxt = S_SDR;
            S_SDR: begin
                if (w_fall) begin
                    if (r_bit == BIT_W'(SR_WIDTH - 1)) begin
                        w_state_nxt = S_UDR;
                        w_bit_nxt   = '0;
                    end else begin
                        w_bit_nxt   = r_bit + BIT_W'(1);
                    end
                end
            end
            S_UDR:  if (w_fall)   w_state_nxt = S_RESP;
            S_RESP: begin
                if (r_rsp_valid && bus.rsp_ready) begin
                    w_state_nxt     = S_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end else begin
                    w_rsp_valid_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs and the shift/capture datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_ir_out    <= '0;
            r_ir_in     <= '0;
            r_tdi       <= 1'b0;
            r_uir       <= 1'b0;
            r_cdr       <= 1'b0;
            r_sdr       <= 1'b0;
            r_udr       <= 1'b0;
            r_rti       <= 1'b1;
        end else begin
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rti       <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_RESP);
            r_uir       <= (w_state_nxt == S_UIR);
            r_cdr       <= (w_state_nxt == S_CDR);
            r_sdr       <= (w_state_nxt == S_SDR);
            r_udr       <= (w_state_nxt == S_UDR);
            if (w_accept) begin
                r_ir_in <= bus.cmd_ir;
                r_tx    <= bus.cmd_data;
            end
            if (w_state_nxt == S_SDR) begin
                if (w_fall) begin
                    r_tdi <= r_tx[0];
                    r_tx  <= r_tx >> 1;
                end
            end else begin
                r_tdi <= 1'b0;
            end
            if ((r_state == S_SDR) && w_rise) r_rx <= {bus.vji_tdo, r_rx[SR_WIDTH-1:1]};
            if ((r_state == S_UIR) && w_rise) r_ir_out <= bus.vji_ir_out;
        end
    end

    assign bus.cmd_ready  = r_cmd_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_data   = r_rx;
    assign bus.rsp_ir_out = r_ir_out;
    assign bus.vji_tck    = w_tck;
    assign bus.vji_tdi    = r_tdi;
    assign bus.vji_ir_in  = r_ir_in;
    assign bus.vji_uir    = r_uir;
    assign bus.vji_cdr    = r_cdr;
    assign bus.vji_sdr    = r_sdr;
    assign bus.vji_udr    = r_udr;
    assign bus.vji_rti    = r_rti;

endmodule

// File: tb/tb_debug_scan_master.sv
// Bench for debug_scan_master: behavioural vJTAG slave, scoreboard queues, per-scenario tasks.
module tb_debug_scan_master;
    import debug_scan_pkg::*;

    localparam int unsigned SRW = 38;
    localparam int unsigned IRW = 2;
    localparam logic [SRW-1:0] SLAVE_WORD = 38'h3F_0000_1234;
    localparam logic [IRW-1:0] SLAVE_IR   = 2'b10;
    localparam logic [50:0] RST_VEC = {1'b0, 1'b0, 38'd0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1};

    typedef struct packed {
        logic [SRW-1:0] rsp;
        logic [IRW-1:0] ir;
        logic [SRW-1:0] snap;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    debug_scan_if #(.SR_WIDTH(SRW), .IR_WIDTH(IRW)) b0 ();
    debug_scan_if #(.SR_WIDTH(SRW), .IR_WIDTH(IRW)) b1 ();

    debug_scan_master #(.SR_WIDTH(SRW), .IR_WIDTH(IRW), .TCK_DIV(2)) u_dut0 (
        .clk(clk), .reset(reset), .bus(b0));
    debug_scan_master #(.SR_WIDTH(SRW), .IR_WIDTH(IRW), .TCK_DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(b1));

    // Slave models: load on CDR, shift right with tdi into the MSB on SDR, snapshot on UDR.
    logic [SRW-1:0] sr0 = '0, snap0 = '0, sr1 = '0, snap1 = '0;
    always @(posedge b0.vji_tck) begin
        if (b0.vji_cdr) sr0 <= SLAVE_WORD;
        if (b0.vji_sdr) sr0 <= {b0.vji_tdi, sr0[SRW-1:1]};
        if (b0.vji_udr) snap0 <= sr0;
    end
    always @(posedge b1.vji_tck) begin
        if (b1.vji_cdr) sr1 <= SLAVE_WORD;
        if (b1.vji_sdr) sr1 <= {b1.vji_tdi, sr1[SRW-1:1]};
        if (b1.vji_udr) snap1 <= sr1;
    end
    assign b0.vji_tdo    = sr0[0];
    assign b0.vji_ir_out = SLAVE_IR;
    assign b1.vji_tdo    = sr1[0];
    assign b1.vji_ir_out = SLAVE_IR;
    assign b1.rsp_ready  = 1'b1;

    // Sequence monitor on DUT0: pulse counts per strobe, overlap and stability across tck rises.
    int mon_rise = 0, mon_uir = 0, mon_cdr = 0, mon_sdr = 0, mon_udr = 0, mon_ovl = 0, mon_stab = 0;
    logic [7:0] prev_snap = '0;
    logic [7:0] cur_snap;
    logic       prev_tck = 1'b0;
    always @(negedge clk) begin
        cur_snap = {b0.vji_tdi, b0.vji_ir_in, b0.vji_uir, b0.vji_cdr, b0.vji_sdr, b0.vji_udr, b0.vji_rti};
        if (b0.vji_tck && !prev_tck) begin
            mon_rise++;
            if (cur_snap !== prev_snap) mon_stab++;
            if (b0.vji_uir) mon_uir++;
            if (b0.vji_cdr) mon_cdr++;
            if (b0.vji_sdr) mon_sdr++;
            if (b0.vji_udr) mon_udr++;
        end
        if ($countones({b0.vji_uir, b0.vji_cdr, b0.vji_sdr, b0.vji_udr}) > 1) mon_ovl++;
        if (b0.vji_rti && (b0.vji_uir || b0.vji_cdr || b0.vji_sdr || b0.vji_udr)) mon_ovl++;
        prev_snap = cur_snap;
        prev_tck  = b0.vji_tck;
    end

    function automatic logic [50:0] outs0();
        return {b0.cmd_ready, b0.rsp_valid, b0.rsp_data, b0.rsp_ir_out, b0.vji_tck, b0.vji_tdi,
                b0.vji_ir_in, b0.vji_uir, b0.vji_cdr, b0.vji_sdr, b0.vji_udr, b0.vji_rti};
    endfunction

    function automatic logic [50:0] outs1();
        return {b1.cmd_ready, b1.rsp_valid, b1.rsp_data, b1.rsp_ir_out, b1.vji_tck, b1.vji_tdi,
                b1.vji_ir_in, b1.vji_uir, b1.vji_cdr, b1.vji_sdr, b1.vji_udr, b1.vji_rti};
    endfunction

    task automatic send0(input logic [IRW-1:0] ir, input logic [SRW-1:0] data, output int acc);
        int k = 0;
        @(negedge clk);
        b0.cmd_ir = ir; b0.cmd_data = data; b0.cmd_valid = 1'b1;
        while (b0.cmd_ready !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
        n_tests++;
        if (b0.cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL accept0: cmd_ready=%b required 1", b0.cmd_ready);
        end
        @(posedge clk); #1;
        acc = cyc;
        b0.cmd_valid = 1'b0;
        q0.push_back('{rsp: SLAVE_WORD, ir: SLAVE_IR, snap: data});
    endtask

    task automatic wait_rsp0(output int seen);
        int k = 0;
        while (b0.rsp_valid !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
        seen = cyc;
        n_tests++;
        if (b0.rsp_valid !== 1'b1) begin
            n_fail++; $display("FAIL rsp_timeout0: rsp_valid=%b required 1", b0.rsp_valid);
        end
    endtask

    // Compares the held response against the scoreboard, then completes the handshake.
    task automatic recv0(input string tag);
        exp_t e;
        n_tests++;
        if (q0.size() == 0) begin
            n_fail++; $display("FAIL %s_sb: queue size 0 required 1", tag); return;
        end
        e = q0.pop_front();
        n_tests += 3;
        if (b0.rsp_data !== e.rsp) begin
            n_fail++; $display("FAIL %s_data: got %h required %h", tag, b0.rsp_data, e.rsp);
        end
        if (b0.rsp_ir_out !== e.ir) begin
            n_fail++; $display("FAIL %s_irout: got %b required %b", tag, b0.rsp_ir_out, e.ir);
        end
        if (snap0 !== e.snap) begin
            n_fail++; $display("FAIL %s_udr_snap: got %h required %h", tag, snap0, e.snap);
        end
        b0.rsp_ready = 1'b1;
        @(posedge clk); #1;
        b0.rsp_ready = 1'b0;
        n_tests++;
        if ({b0.rsp_valid, b0.cmd_ready} !== 2'b01) begin
            n_fail++; $display("FAIL %s_release: rsp_valid,cmd_ready=%b required 01", tag,
                               {b0.rsp_valid, b0.cmd_ready});
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        n_tests += 2;
        if (outs0() !== RST_VEC) begin
            n_fail++; $display("FAIL reset_vals0: got %h required %h", outs0(), RST_VEC);
        end
        if (outs1() !== RST_VEC) begin
            n_fail++; $display("FAIL reset_vals1: got %h required %h", outs1(), RST_VEC);
        end
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({b0.cmd_ready, b1.cmd_ready} !== 2'b11) begin
            n_fail++; $display("FAIL ready_after_reset: got %b required 11", {b0.cmd_ready, b1.cmd_ready});
        end
    endtask

    task automatic test_basic();
        int acc, seen;
        int r0 = mon_rise, u0 = mon_uir, c0 = mon_cdr, s0 = mon_sdr, d0 = mon_udr;
        int o0 = mon_ovl, t0 = mon_stab;
        send0(DBG_IR_TRACEMEM, 38'h15_5555_5555, acc);
        wait_rsp0(seen);
        n_tests += 2;
        if (seen - acc != 165) begin
            n_fail++; $display("FAIL basic_latency: got %0d required 165", seen - acc);
        end
        if (b0.vji_ir_in !== 2'b01) begin
            n_fail++; $display("FAIL basic_ir_in: got %b required 01", b0.vji_ir_in);
        end
        recv0("basic");
        n_tests += 7;
        if (mon_rise - r0 != 41) begin n_fail++; $display("FAIL seq_tck: got %0d required 41", mon_rise - r0); end
        if (mon_uir - u0 != 1)   begin n_fail++; $display("FAIL seq_uir: got %0d required 1", mon_uir - u0); end
        if (mon_cdr - c0 != 1)   begin n_fail++; $display("FAIL seq_cdr: got %0d required 1", mon_cdr - c0); end
        if (mon_sdr - s0 != 38)  begin n_fail++; $display("FAIL seq_sdr: got %0d required 38", mon_sdr - s0); end
        if (mon_udr - d0 != 1)   begin n_fail++; $display("FAIL seq_udr: got %0d required 1", mon_udr - d0); end
        if (mon_ovl - o0 != 0)   begin n_fail++; $display("FAIL seq_overlap: got %0d required 0", mon_ovl - o0); end
        if (mon_stab - t0 != 0)  begin n_fail++; $display("FAIL seq_stable: got %0d required 0", mon_stab - t0); end
    endtask

    task automatic test_back_to_back();
        logic [SRW-1:0] da = 38'h2A_AAAA_AAAA, db = 38'h01_2345_6789;
        int acc1 = 0, acc2 = 0, r1 = 0, k = 0;
        exp_t e;
        @(negedge clk);
        b1.cmd_ir = DBG_IR_TRACECTRL; b1.cmd_data = da; b1.cmd_valid = 1'b1;
        while (b1.cmd_ready !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
        acc1 = cyc + 1;
        q1.push_back('{rsp: SLAVE_WORD, ir: SLAVE_IR, snap: da});
        @(negedge clk);
        b1.cmd_ir = DBG_IR_OCIMEM; b1.cmd_data = db;
        for (int j = 0; j < 2; j++) begin
            k = 0;
            while (b1.rsp_valid !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
            r1 = cyc;
            e = q1.pop_front();
            n_tests += 4;
            if (r1 - (j == 0 ? acc1 : acc2) != 83) begin
                n_fail++; $display("FAIL b2b_latency%0d: got %0d required 83", j, r1 - (j == 0 ? acc1 : acc2));
            end
            if (b1.rsp_data !== e.rsp) begin
                n_fail++; $display("FAIL b2b_data%0d: got %h required %h", j, b1.rsp_data, e.rsp);
            end
            if (b1.rsp_ir_out !== e.ir) begin
                n_fail++; $display("FAIL b2b_irout%0d: got %b required %b", j, b1.rsp_ir_out, e.ir);
            end
            if (snap1 !== e.snap) begin
                n_fail++; $display("FAIL b2b_snap%0d: got %h required %h", j, snap1, e.snap);
            end
            @(negedge clk);
            n_tests++;
            if ({b1.rsp_valid, b1.cmd_ready} !== 2'b01) begin
                n_fail++; $display("FAIL b2b_width%0d: rsp_valid,cmd_ready=%b required 01", j,
                                   {b1.rsp_valid, b1.cmd_ready});
            end
            if (j == 0) begin
                acc2 = cyc + 1;
                q1.push_back('{rsp: SLAVE_WORD, ir: SLAVE_IR, snap: db});
                @(negedge clk);
                b1.cmd_valid = 1'b0;
                n_tests++;
                if (b1.cmd_ready !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_accept2: cmd_ready=%b required 0", b1.cmd_ready);
                end
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [SRW-1:0] d = {6'($urandom), 32'($urandom)};
        int acc, seen, k = 0, base = mon_sdr, hits = 0;
        send0(DBG_IR_OCIMEM, d, acc);
        while (mon_sdr - base < 20 && k < 2000) begin @(negedge clk); k++; end
        while (b0.vji_tck === 1'b1 && k < 2000) begin @(negedge clk); k++; end
        n_tests++;
        if ({b0.vji_sdr, b0.vji_tdi} !== {1'b1, d[20]}) begin
            n_fail++; $display("FAIL rst_bit20: sdr,tdi=%b required %b", {b0.vji_sdr, b0.vji_tdi}, {1'b1, d[20]});
        end
        #1 reset = 1'b1;
        #1;
        n_tests++;
        if (outs0() !== RST_VEC) begin
            n_fail++; $display("FAIL rst_async: got %h required %h", outs0(), RST_VEC);
        end
        void'(q0.pop_back());
        @(negedge clk); @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (b0.rsp_valid !== 1'b0) hits++;
        end
        n_tests++;
        if (hits != 0) begin n_fail++; $display("FAIL rst_no_rsp: rsp_valid high %0d cycles required 0", hits); end
        send0(DBG_IR_BREAK, ~d, acc);
        wait_rsp0(seen);
        n_tests++;
        if (seen - acc != 165) begin n_fail++; $display("FAIL rst_next_latency: got %0d required 165", seen - acc); end
        recv0("rst_next");
    endtask

    task automatic test_hold_rsp();
        int acc, seen, bad = 0;
        send0(DBG_IR_BREAK, 38'h30_0F0F_F0F0, acc);
        wait_rsp0(seen);
        n_tests++;
        if (seen - acc != 165) begin n_fail++; $display("FAIL hold_latency: got %0d required 165", seen - acc); end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            b0.cmd_valid = (i % 3 == 0);
            if (b0.rsp_valid !== 1'b1 || b0.rsp_data !== SLAVE_WORD || b0.cmd_ready !== 1'b0) bad++;
        end
        b0.cmd_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL hold_stable: bad cycles %0d required 0", bad); end
        recv0("hold");
    endtask

    initial begin
        b0.cmd_valid = 1'b0; b0.cmd_ir = '0; b0.cmd_data = '0; b0.rsp_ready = 1'b0;
        b1.cmd_valid = 1'b0; b1.cmd_ir = '0; b1.cmd_data = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_mid_scan();
        test_hold_rsp();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
